// File: rtl/syn_count_multi_if.sv
// ----------------------------------------------------------------------------
// syn_count_multi_if
// Bundles the control inputs and count outputs of syn_count_multi.
//   en    : count enable               (master -> slave)
//   mode  : 00 up, 01 down, 10 Johnson, 11 ring (master -> slave)
//   load  : synchronous load of d      (master -> slave)
//   d     : load value, WIDTH bits     (master -> slave)
//   q     : registered count           (slave -> master)
//   tc    : terminal count flag        (slave -> master)
//   err   : one-cycle illegal-state correction pulse (slave -> master)
// ----------------------------------------------------------------------------
interface syn_count_multi_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             err;

  modport master (
    output en, mode, load, d,
    input  q, tc, err
  );

  modport slave (
    input  en, mode, load, d,
    output q, tc, err
  );
endinterface

// File: rtl/syn_count_multi.sv
// ----------------------------------------------------------------------------
// syn_count_multi
// WIDTH-bit counter with four run-time sequences (modulo up, modulo down,
// Johnson, one-hot ring), synchronous load, enable, terminal-count flag and
// self-correction of illegal states on an enabled step.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (q=0, previous mode=up, err=0)
//   bus   : syn_count_multi_if slave (en, mode, load, d in; q, tc, err out)
// ----------------------------------------------------------------------------
module syn_count_multi #(
  parameter int WIDTH = 4,
  parameter int MOD   = 2**WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  syn_count_multi_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_JOHN = 2'b10,
    MODE_RING = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ZERO_C     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_C      = WIDTH'(1);
  localparam logic [WIDTH-1:0] MOD_M1_C   = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] MSB_ONLY_C = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH:0]   MOD_WIDE_C = (WIDTH+1)'(MOD);

  logic [WIDTH-1:0] q_r;
  logic [1:0]       mode_r;
  logic             err_r;

  logic [WIDTH-1:0] seed_s;
  logic [WIDTH-1:0] term_s;
  logic [WIDTH-1:0] next_s;
  logic             fix_s;
  logic             bin_illegal_s;
  logic             tc_s;

  // A Johnson state is legal when adjacent bits differ in at most one place.
  function automatic logic john_legal(input logic [WIDTH-1:0] v);
    logic [WIDTH-2:0] diff;
    diff = v[WIDTH-1:1] ^ v[WIDTH-2:0];
    return ((diff & (diff - (WIDTH-1)'(1))) == {(WIDTH-1){1'b0}});
  endfunction

  // Exactly one bit set.
  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != ZERO_C) && ((v & (v - ONE_C)) == ZERO_C);
  endfunction

  // Binary states at or above the modulus are unreachable by counting.
  assign bin_illegal_s = ({1'b0, q_r} >= MOD_WIDE_C);

  // Seed and terminal state for the currently requested mode.
  always_comb begin
    seed_s = ZERO_C;
    term_s = MOD_M1_C;
    case (mode_e'(bus.mode))
      MODE_UP: begin
        seed_s = ZERO_C;
        term_s = MOD_M1_C;
      end
      MODE_DOWN: begin
        seed_s = MOD_M1_C;
        term_s = ZERO_C;
      end
      MODE_JOHN: begin
        seed_s = ZERO_C;
        term_s = MSB_ONLY_C;
      end
      MODE_RING: begin
        seed_s = ONE_C;
        term_s = MSB_ONLY_C;
      end
      default: begin
        seed_s = ZERO_C;
        term_s = MOD_M1_C;
      end
    endcase
  end

  // Next count for an enabled step, plus whether that step is a correction.
  always_comb begin
    next_s = q_r;
    fix_s  = 1'b0;
    case (mode_e'(bus.mode))
      MODE_UP: begin
        if (bin_illegal_s) begin
          next_s = ZERO_C;
          fix_s  = 1'b1;
        end else if (q_r == MOD_M1_C) begin
          next_s = ZERO_C;
        end else begin
          next_s = q_r + ONE_C;
        end
      end
      MODE_DOWN: begin
        if (bin_illegal_s) begin
          next_s = MOD_M1_C;
          fix_s  = 1'b1;
        end else if (q_r == ZERO_C) begin
          next_s = MOD_M1_C;
        end else begin
          next_s = q_r - ONE_C;
        end
      end
      MODE_JOHN: begin
        if (john_legal(q_r)) begin
          next_s = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
        end else begin
          next_s = ZERO_C;
          fix_s  = 1'b1;
        end
      end
      MODE_RING: begin
        if (is_onehot(q_r)) begin
          next_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        end else begin
          next_s = ONE_C;
          fix_s  = 1'b1;
        end
      end
      default: begin
        next_s = q_r;
        fix_s  = 1'b0;
      end
    endcase
  end

  // Count register: load beats mode-change seeding beats counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r    <= ZERO_C;
      mode_r <= 2'b00;
      err_r  <= 1'b0;
    end else begin
      // Previous mode tracks the input every edge, even under load or en=0.
      mode_r <= bus.mode;
      if (bus.load) begin
        q_r   <= bus.d;
        err_r <= 1'b0;
      end else if (bus.mode != mode_r) begin
        q_r   <= seed_s;
        err_r <= 1'b0;
      end else if (bus.en) begin
        q_r   <= next_s;
        err_r <= fix_s;
      end else begin
        q_r   <= q_r;
        err_r <= 1'b0;
      end
    end
  end

  // Terminal count is suppressed while loading, disabled, reseeding or in reset.
  always_comb begin
    tc_s = 1'b0;
    if (rst_n && bus.en && !bus.load && (bus.mode == mode_r)) begin
      tc_s = (q_r == term_s);
    end else begin
      tc_s = 1'b0;
    end
  end

  assign bus.q   = q_r;
  assign bus.err = err_r;
  assign bus.tc  = tc_s;

endmodule

// File: tb/tb_syn_count_multi.sv
// ----------------------------------------------------------------------------
// tb_syn_count_multi
// Directed sequences followed by randomized stimulus for syn_count_multi
// (WIDTH=4, MOD=10), checked against a sequence-level reference model.
// ----------------------------------------------------------------------------
module tb_syn_count_multi;
  localparam int W = 4;
  localparam int M = 10;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  // reference model state
  int   mdl_q;
  int   mdl_prev;
  int   mdl_err;
  int   cur_mode;

  syn_count_multi_if #(.WIDTH(W)) bus ();

  syn_count_multi #(.WIDTH(W), .MOD(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // k-th state of the 2W-state Johnson cycle: fill with ones, then drain.
  function automatic int john_state(input int k);
    if (k <= W) return (1 << k) - 1;
    return (((1 << W) - 1) << (k - W)) & ((1 << W) - 1);
  endfunction

  function automatic int seed_of(input int m);
    case (m)
      0: return 0;
      1: return M - 1;
      2: return 0;
      default: return 1;
    endcase
  endfunction

  function automatic int term_of(input int m);
    case (m)
      0: return M - 1;
      1: return 0;
      default: return 1 << (W - 1);
    endcase
  endfunction

  // One enabled step of the sequence in mode m; returns next, sets bad on correction.
  task automatic model_next(input int m, input int q, output int nq, output int bad);
    nq = 0;
    bad = 0;
    case (m)
      0: if (q >= M) begin nq = 0; bad = 1; end else nq = (q + 1) % M;
      1: if (q >= M) begin nq = M - 1; bad = 1; end else nq = (q + M - 1) % M;
      2: begin
        bad = 1;
        for (int k = 0; k < 2 * W; k++)
          if (john_state(k) == q) begin nq = john_state((k + 1) % (2 * W)); bad = 0; end
        if (bad != 0) nq = 0;
      end
      default: begin
        bad = 1;
        for (int k = 0; k < W; k++)
          if ((1 << k) == q) begin nq = 1 << ((k + 1) % W); bad = 0; end
        if (bad != 0) nq = 1;
      end
    endcase
  endtask

  task automatic model_reset();
    mdl_q = 0;
    mdl_prev = 0;
    mdl_err = 0;
  endtask

  // Drive one cycle of inputs, check tc before the edge, q/err after it.
  task automatic step(input int e, input int m, input int l, input int dv);
    int exp_tc;
    int nq;
    int bad;
    bus.en   = e[0];
    bus.mode = m[1:0];
    bus.load = l[0];
    bus.d    = dv[W-1:0];
    cur_mode = m;
    #1;
    exp_tc = (e != 0 && l == 0 && m == mdl_prev && mdl_q == term_of(m)) ? 1 : 0;
    check_val("tc", int'(bus.tc), exp_tc);
    if (l != 0) begin
      nq = dv; bad = 0;
    end else if (m != mdl_prev) begin
      nq = seed_of(m); bad = 0;
    end else if (e != 0) begin
      model_next(m, mdl_q, nq, bad);
    end else begin
      nq = mdl_q; bad = 0;
    end
    @(posedge clk);
    #1;
    mdl_q = nq;
    mdl_err = bad;
    mdl_prev = m;
    check_val("q", int'(bus.q), mdl_q);
    check_val("err", int'(bus.err), mdl_err);
  endtask

  // Asynchronous reset between edges; q must clear without a clock.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("rst_q", int'(bus.q), 0);
    check_val("rst_tc", int'(bus.tc), 0);
    check_val("rst_err", int'(bus.err), 0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    cur_mode = 0;
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.mode = 2'b00;
    bus.load = 1'b0;
    bus.d    = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("reset_q", int'(bus.q), 0);
    check_val("reset_err", int'(bus.err), 0);
    check_val("reset_tc", int'(bus.tc), 0);
    rst_n = 1'b1;

    // up mode: 0..9,0,1
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0);
    check_val("up_after12", int'(bus.q), 2);

    // down mode: seed 9, then down through 0 and wrap
    step(1, 1, 0, 0);
    check_val("down_seed", int'(bus.q), 9);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    check_val("down_wrap", int'(bus.q), 9);

    // Johnson: seed then full 8-state cycle
    step(1, 2, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 2, 0, 0);
    check_val("john_cycle", int'(bus.q), 0);
    step(0, 2, 1, 5);
    step(1, 2, 0, 0);
    check_val("john_fix_q", int'(bus.q), 0);
    check_val("john_fix_err", int'(bus.err), 1);
    step(1, 2, 0, 0);

    // ring: seed 0001, four rotations, then illegal load
    step(1, 3, 0, 0);
    check_val("ring_seed", int'(bus.q), 1);
    for (int i = 0; i < 4; i++) step(1, 3, 0, 0);
    step(0, 3, 1, 6);
    step(1, 3, 0, 0);
    check_val("ring_fix_q", int'(bus.q), 1);
    check_val("ring_fix_err", int'(bus.err), 1);
    step(1, 3, 0, 0);

    // load wins over a simultaneous change to down mode
    step(1, 0, 0, 0);
    step(1, 1, 1, 7);
    check_val("prio_load", int'(bus.q), 7);
    step(1, 1, 0, 0);
    check_val("prio_next", int'(bus.q), 6);

    // illegal binary load corrected on the next enabled step
    step(1, 0, 0, 0);
    step(0, 0, 1, 12);
    step(0, 0, 0, 0);
    check_val("hold_illegal", int'(bus.q), 12);
    step(1, 0, 0, 0);
    check_val("up_fix_err", int'(bus.err), 1);

    // enable low at the terminal state: hold, tc stays low
    step(0, 0, 1, 9);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_val("en0_hold", int'(bus.q), 9);

    // async reset mid-count at q=5, then release into ring mode
    step(0, 0, 1, 4);
    step(1, 0, 0, 0);
    check_val("pre_reset", int'(bus.q), 5);
    async_reset();
    step(1, 3, 0, 0);
    check_val("ring_after_rst", int'(bus.q), 1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      int e;
      int m;
      int l;
      int dv;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        async_reset();
      end else begin
        e  = ($urandom_range(0, 7) != 0) ? 1 : 0;
        m  = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 3)) : cur_mode;
        l  = ($urandom_range(0, 12) == 0) ? 1 : 0;
        dv = int'($urandom_range(0, 15));
        step(e, m, l, dv);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
